// File: rtl/bubble_split_ctrl.sv
// -----------------------------------------------------------------------------
// bubble_split_ctrl
//
// Slot manager placed in front of the bubble object instances. It tracks which
// of NUM_SLOTS bubble slots hold a live bubble, seeds slot 0 at level start and
// services split requests. When a bubble splits, its own slot is relaunched as
// the left child and the right child goes to the lowest free slot. A size-0/1
// bubble pops instead of splitting.
//
// Optional build feature: define SPLIT_SCORE_EN to add a saturating score
// output that accumulates (5 - s) for every serviced split of size s.
//
// Ports
//   clk         system clock
//   resetN      asynchronous active-low reset
//   levelStart  one-cycle pulse: clear all slots, seed slot 0
//   initSize    size of the seeded bubble
//   initX/initY seed top-left position
//   split       per-slot split pulse from the bubble instances
//   parentX/Y   packed per-slot top-left position (slot i at [11i+10:11i])
//   parentSize  packed per-slot size_out (slot i at [3i+2:3i])
//   start       one-cycle launch pulse per slot
//   size        registered launch size per slot (packed, 3 bits each)
//   direction   launch direction per slot, 0 = left, 1 = right
//   startTopX/Y launch position per slot (packed, 11 bits each)
//   active      slot currently holds a live bubble
//   allCleared  nothing active, nothing pending, FSM idle, no level request
//   dropCount   right children dropped for lack of a free slot (saturating)
//   score       (SPLIT_SCORE_EN only) saturating split score
// -----------------------------------------------------------------------------
module bubble_split_ctrl #(
  parameter int NUM_SLOTS = 8,
  parameter int BASE_W    = 8,
  parameter int X_MAX     = 639
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   levelStart,
  input  logic [2:0]             initSize,
  input  logic [10:0]            initX,
  input  logic [10:0]            initY,
  input  logic [NUM_SLOTS-1:0]   split,
  input  logic [NUM_SLOTS*11-1:0] parentX,
  input  logic [NUM_SLOTS*11-1:0] parentY,
  input  logic [NUM_SLOTS*3-1:0]  parentSize,
  output logic [NUM_SLOTS-1:0]   start,
  output logic [NUM_SLOTS*3-1:0]  size,
  output logic [NUM_SLOTS-1:0]   direction,
  output logic [NUM_SLOTS*11-1:0] startTopX,
  output logic [NUM_SLOTS*11-1:0] startTopY,
  output logic [NUM_SLOTS-1:0]   active,
  output logic                   allCleared,
  output logic [7:0]             dropCount
`ifdef SPLIT_SCORE_EN
  ,
  output logic [15:0]            score
`endif
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_SLOTS-1:0] active_reg,  active_next;
  logic [NUM_SLOTS-1:0] pending_reg, pending_next;
  logic [NUM_SLOTS-1:0] launch_reg,  launch_next;
  logic [NUM_SLOTS-1:0] start_reg,   start_next;
  logic [NUM_SLOTS-1:0] dir_reg,     dir_next;

  logic [2:0]  size_reg  [NUM_SLOTS];
  logic [2:0]  size_next [NUM_SLOTS];
  logic [10:0] x_reg     [NUM_SLOTS];
  logic [10:0] x_next    [NUM_SLOTS];
  logic [10:0] y_reg     [NUM_SLOTS];
  logic [10:0] y_next    [NUM_SLOTS];

  // Parent geometry captured at the split edge; the bubble may keep moving
  // while the request waits its turn.
  logic [2:0]  cap_size_reg [NUM_SLOTS];
  logic [2:0]  cap_size_next[NUM_SLOTS];
  logic [10:0] cap_x_reg    [NUM_SLOTS];
  logic [10:0] cap_x_next   [NUM_SLOTS];
  logic [10:0] cap_y_reg    [NUM_SLOTS];
  logic [10:0] cap_y_next   [NUM_SLOTS];

  logic        level_pend_reg, level_pend_next;
  logic [7:0]  drop_reg, drop_next;
  logic        clr_reg, clr_next;

`ifdef SPLIT_SCORE_EN
  logic [15:0] score_reg, score_next;
  logic [15:0] score_inc;
  logic [16:0] score_sum;
`endif

  // Service-path working signals
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [2:0]       par_s;
  logic [10:0]      par_x;
  logic [10:0]      par_y;
  logic [2:0]       child_s;
  logic [11:0]      child_w;
  logic [11:0]      right_sum;
  logic [11:0]      right_lim;
  logic [10:0]      right_x;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg      <= IDLE;
      active_reg     <= '0;
      pending_reg    <= '0;
      launch_reg     <= '0;
      start_reg      <= '0;
      dir_reg        <= '0;
      level_pend_reg <= 1'b0;
      drop_reg       <= '0;
      clr_reg        <= 1'b0;
`ifdef SPLIT_SCORE_EN
      score_reg      <= '0;
`endif
      for (int i = 0; i < NUM_SLOTS; i++) begin
        size_reg[i]     <= '0;
        x_reg[i]        <= '0;
        y_reg[i]        <= '0;
        cap_size_reg[i] <= '0;
        cap_x_reg[i]    <= '0;
        cap_y_reg[i]    <= '0;
      end
    end else begin
      state_reg      <= state_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      launch_reg     <= launch_next;
      start_reg      <= start_next;
      dir_reg        <= dir_next;
      level_pend_reg <= level_pend_next;
      drop_reg       <= drop_next;
      clr_reg        <= clr_next;
`ifdef SPLIT_SCORE_EN
      score_reg      <= score_next;
`endif
      for (int i = 0; i < NUM_SLOTS; i++) begin
        size_reg[i]     <= size_next[i];
        x_reg[i]        <= x_next[i];
        y_reg[i]        <= y_next[i];
        cap_size_reg[i] <= cap_size_next[i];
        cap_x_reg[i]    <= cap_x_next[i];
        cap_y_reg[i]    <= cap_y_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    active_next     = active_reg;
    pending_next    = pending_reg;
    launch_next     = launch_reg;
    start_next      = '0;
    dir_next        = dir_reg;
    // A levelStart is always latched first and acted on from IDLE, so its
    // launch latency matches a split's regardless of FSM state.
    level_pend_next = level_pend_reg | levelStart;
    drop_next       = drop_reg;
    size_next       = size_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    cap_size_next   = cap_size_reg;
    cap_x_next      = cap_x_reg;
    cap_y_next      = cap_y_reg;
`ifdef SPLIT_SCORE_EN
    score_next      = score_reg;
    score_inc       = '0;
    score_sum       = '0;
`endif
    sel_found       = 1'b0;
    sel_idx         = '0;
    free_found      = 1'b0;
    free_idx        = '0;
    par_s           = '0;
    par_x           = '0;
    par_y           = '0;
    child_s         = '0;
    child_w         = '0;
    right_sum       = '0;
    right_lim       = '0;
    right_x         = '0;

    // Capture: only live slots, and an already-pending request is not
    // overwritten by a later one.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (split[i] && active_reg[i] && !pending_reg[i]) begin
        pending_next[i]  = 1'b1;
        cap_size_next[i] = parentSize[i*3 +: 3];
        cap_x_next[i]    = parentX[i*11 +: 11];
        cap_y_next[i]    = parentY[i*11 +: 11];
      end
    end

    unique case (state_reg)
      IDLE: begin
        if (level_pend_reg) begin
          // Level restart flushes everything, including captures on this edge.
          pending_next    = '0;
          active_next     = '0;
          launch_next     = '0;
          launch_next[0]  = 1'b1;
          size_next[0]    = initSize;
          dir_next[0]     = 1'b0;
          x_next[0]       = initX;
          y_next[0]       = initY;
          level_pend_next = levelStart;
`ifdef SPLIT_SCORE_EN
          score_next      = '0;
`endif
          state_next      = ISSUE;
        end else if (!levelStart && (pending_reg != '0)) begin
          // A fresh levelStart this cycle holds off split service so it can
          // take priority on the next IDLE cycle.
          for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
              sel_found = 1'b1;
              sel_idx   = IDX_W'(i);
            end
          end
          pending_next[sel_idx] = 1'b0;
          par_s = cap_size_reg[sel_idx];
          par_x = cap_x_reg[sel_idx];
          par_y = cap_y_reg[sel_idx];

`ifdef SPLIT_SCORE_EN
          // Sizes above 5 would give a negative award; they score nothing.
          score_inc  = (par_s <= 3'd5) ? (16'd5 - {13'd0, par_s}) : 16'd0;
          score_sum  = {1'b0, score_reg} + {1'b0, score_inc};
          score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`endif

          if (par_s <= 3'd1) begin
            // Smallest bubbles pop: free the slot, launch nothing.
            active_next[sel_idx] = 1'b0;
            launch_next          = '0;
            state_next           = GAP;
          end else begin
            child_s = par_s - 3'd1;
            child_w = 12'(BASE_W) << child_s;

            launch_next          = '0;
            launch_next[sel_idx] = 1'b1;
            size_next[sel_idx]   = child_s;
            dir_next[sel_idx]    = 1'b0;
            x_next[sel_idx]      = par_x;
            y_next[sel_idx]      = par_y;

            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
              if (!active_reg[i] && (IDX_W'(i) != sel_idx)) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
              end
            end

            // Right child sits one child-width to the right, kept on screen.
            right_sum = {1'b0, par_x} + child_w;
            right_lim = 12'(X_MAX + 1) - child_w;
            right_x   = (right_sum > right_lim) ? right_lim[10:0] : right_sum[10:0];

            if (free_found) begin
              launch_next[free_idx] = 1'b1;
              size_next[free_idx]   = child_s;
              dir_next[free_idx]    = 1'b1;
              x_next[free_idx]      = right_x;
              y_next[free_idx]      = par_y;
            end else if (drop_reg != 8'hFF) begin
              drop_next = drop_reg + 8'd1;
            end
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        // Launch data was loaded on entry; pulse start and mark live together.
        start_next  = launch_reg;
        active_next = active_next | launch_reg;
        state_next  = GAP;
      end

      GAP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    clr_next = (active_next == '0) && (pending_next == '0) &&
               (state_next == IDLE) && !level_pend_next;
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_out
      assign size[gi*3 +: 3]       = size_reg[gi];
      assign startTopX[gi*11 +: 11] = x_reg[gi];
      assign startTopY[gi*11 +: 11] = y_reg[gi];
    end
  endgenerate

  assign start      = start_reg;
  assign direction  = dir_reg;
  assign active     = active_reg;
  assign allCleared = clr_reg;
  assign dropCount  = drop_reg;
`ifdef SPLIT_SCORE_EN
  assign score      = score_reg;
`endif

endmodule

// File: tb/tb_bubble_split_ctrl.sv
module tb_bubble_split_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          levelStart;
  logic [2:0]    initSize;
  logic [10:0]   initX;
  logic [10:0]   initY;
  logic [N-1:0]  split;
  logic [N*11-1:0] parentX;
  logic [N*11-1:0] parentY;
  logic [N*3-1:0]  parentSize;
  logic [N-1:0]  start;
  logic [N*3-1:0] size;
  logic [N-1:0]  direction;
  logic [N*11-1:0] startTopX;
  logic [N*11-1:0] startTopY;
  logic [N-1:0]  active;
  logic          allCleared;
  logic [7:0]    dropCount;
`ifdef SPLIT_SCORE_EN
  logic [15:0]   score;
`endif

  always #5 clk = ~clk;

  bubble_split_ctrl #(.NUM_SLOTS(N), .BASE_W(8), .X_MAX(639)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .levelStart (levelStart),
    .initSize   (initSize),
    .initX      (initX),
    .initY      (initY),
    .split      (split),
    .parentX    (parentX),
    .parentY    (parentY),
    .parentSize (parentSize),
    .start      (start),
    .size       (size),
    .direction  (direction),
    .startTopX  (startTopX),
    .startTopY  (startTopY),
    .active     (active),
    .allCleared (allCleared),
    .dropCount  (dropCount)
`ifdef SPLIT_SCORE_EN
    ,
    .score      (score)
`endif
  );

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  typedef struct {
    int          edge_n;
    logic [7:0]  st;
    logic [7:0]  act;
    int          a_idx;
    logic [2:0]  a_s;
    logic        a_d;
    logic [10:0] a_x;
    logic [10:0] a_y;
    bit          b_v;
    int          b_idx;
    logic [2:0]  b_s;
    logic        b_d;
    logic [10:0] b_x;
    logic [10:0] b_y;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input int e, input logic [7:0] st, input logic [7:0] act,
                          input int ai, input logic [2:0] as_, input logic ad,
                          input logic [10:0] ax, input logic [10:0] ay,
                          input bit bv, input int bi, input logic [2:0] bs, input logic bd,
                          input logic [10:0] bx, input logic [10:0] by);
    exp_t t;
    t.edge_n = e; t.st = st; t.act = act;
    t.a_idx = ai; t.a_s = as_; t.a_d = ad; t.a_x = ax; t.a_y = ay;
    t.b_v = bv; t.b_idx = bi; t.b_s = bs; t.b_d = bd; t.b_x = bx; t.b_y = by;
    sb.push_back(t);
  endtask

  // Scoreboard consumer: every start pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (start !== '0) begin
        exp_t e;
        if (sb.size() == 0) begin
          check("unexpected_start", start, 0);
        end else begin
          e = sb.pop_front();
          check("start_mask", start, e.st);
          check("start_edge", edges, e.edge_n);
          check("active_at_start", active, e.act);
          check("left_size", size[e.a_idx*3 +: 3], e.a_s);
          check("left_dir", direction[e.a_idx], e.a_d);
          check("left_x", startTopX[e.a_idx*11 +: 11], e.a_x);
          check("left_y", startTopY[e.a_idx*11 +: 11], e.a_y);
          if (e.b_v) begin
            check("right_size", size[e.b_idx*3 +: 3], e.b_s);
            check("right_dir", direction[e.b_idx], e.b_d);
            check("right_x", startTopX[e.b_idx*11 +: 11], e.b_x);
            check("right_y", startTopY[e.b_idx*11 +: 11], e.b_y);
          end
          $display("launch edge=%0d start=%b active=%b", edges, start, active);
        end
      end
    end
  end

  task automatic set_parent(input int i, input logic [2:0] s, input logic [10:0] x, input logic [10:0] y);
    parentSize[i*3 +: 3] = s;
    parentX[i*11 +: 11]  = x;
    parentY[i*11 +: 11]  = y;
  endtask

  task automatic do_split(input logic [7:0] m, output int k);
    @(posedge clk); #1;
    k = edges;
    split = m;
    @(posedge clk); #1;
    split = '0;
  endtask

  task automatic do_level(input logic [2:0] s, input logic [10:0] x, input logic [10:0] y, output int k);
    @(posedge clk); #1;
    k = edges;
    initSize = s; initX = x; initY = y;
    levelStart = 1'b1;
    @(posedge clk); #1;
    levelStart = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size(), 0);
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    resetN = 1'b0; levelStart = 1'b0; initSize = '0; initX = '0; initY = '0;
    split = '0; parentX = '0; parentY = '0; parentSize = '0;

    // Reset values
    #12;
    check("rst_start", start, 0);
    check("rst_active", active, 0);
    check("rst_drop", dropCount, 0);
    check("rst_clr", allCleared, 0);
    check("rst_size", size, 0);
    check("rst_dir", direction, 0);
    check("rst_x", startTopX, 0);
    check("rst_y", startTopY, 0);
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    check("idle_clr", allCleared, 1);

    // Level start seeds slot 0
    do_level(3'd3, 11'd100, 11'd50, k);
    check("lvl_clr_low", allCleared, 0);
    push_exp(k + 3, 8'h01, 8'h01, 0, 3'd3, 1'b0, 11'd100, 11'd50, 0, 0, 0, 0, 0, 0);
    wait_drain();

    // Basic split of size 3 at X=100
    set_parent(0, 3'd3, 11'd100, 11'd50);
    do_split(8'h01, k);
    push_exp(k + 3, 8'h03, 8'h03, 0, 3'd2, 1'b0, 11'd100, 11'd50, 1, 1, 3'd2, 1'b1, 11'd132, 11'd50);
    wait_drain();

    // Grow to four live slots
    set_parent(0, 3'd3, 11'd200, 11'd60);
    do_split(8'h01, k);
    push_exp(k + 3, 8'h05, 8'h07, 0, 3'd2, 1'b0, 11'd200, 11'd60, 1, 2, 3'd2, 1'b1, 11'd232, 11'd60);
    wait_drain();
    set_parent(0, 3'd3, 11'd300, 11'd70);
    do_split(8'h01, k);
    push_exp(k + 3, 8'h09, 8'h0F, 0, 3'd2, 1'b0, 11'd300, 11'd70, 1, 3, 3'd2, 1'b1, 11'd332, 11'd70);
    wait_drain();

    // Simultaneous splits on slots 1 and 3: serviced in index order, 3 cycles apart
    set_parent(1, 3'd2, 11'd140, 11'd80);
    set_parent(3, 3'd2, 11'd400, 11'd90);
    do_split(8'h0A, k);
    push_exp(k + 3, 8'h12, 8'h1F, 1, 3'd1, 1'b0, 11'd140, 11'd80, 1, 4, 3'd1, 1'b1, 11'd156, 11'd80);
    push_exp(k + 6, 8'h28, 8'h3F, 3, 3'd1, 1'b0, 11'd400, 11'd90, 1, 5, 3'd1, 1'b1, 11'd416, 11'd90);
    wait_drain();

    // Pop of the only active bubble
    do_level(3'd1, 11'd10, 11'd20, k);
    push_exp(k + 3, 8'h01, 8'h01, 0, 3'd1, 1'b0, 11'd10, 11'd20, 0, 0, 0, 0, 0, 0);
    wait_drain();
    set_parent(0, 3'd1, 11'd10, 11'd20);
    do_split(8'h01, k);
    @(posedge clk); #1;
    check("pop_active", active, 0);
    check("pop_clr_early", allCleared, 0);
    @(posedge clk); #1;
    check("pop_clr", allCleared, 1);
    repeat (4) @(posedge clk); #1;

    // Fill all eight slots
    do_level(3'd4, 11'd0, 11'd0, k);
    push_exp(k + 3, 8'h01, 8'h01, 0, 3'd4, 1'b0, 11'd0, 11'd0, 0, 0, 0, 0, 0, 0);
    wait_drain();
    for (int i = 1; i < N; i++) begin
      set_parent(0, 3'd4, 11'd0, 11'd0);
      do_split(8'h01, k);
      push_exp(k + 3, 8'(1 | (1 << i)), 8'((1 << (i + 1)) - 1), 0, 3'd3, 1'b0, 11'd0, 11'd0,
               1, i, 3'd3, 1'b1, 11'd64, 11'd0);
      wait_drain();
    end

    // No free slot: right child dropped
    set_parent(5, 3'd2, 11'd500, 11'd30);
    do_split(8'h20, k);
    push_exp(k + 3, 8'h20, 8'hFF, 5, 3'd1, 1'b0, 11'd500, 11'd30, 0, 0, 0, 0, 0, 0);
    wait_drain();
    check("drop_one", dropCount, 1);

    // Free slot 7 by popping it, then clamp the right child at the screen edge
    set_parent(7, 3'd1, 11'd0, 11'd0);
    do_split(8'h80, k);
    repeat (4) @(posedge clk); #1;
    check("pop7_active", active, 8'h7F);
    set_parent(6, 3'd2, 11'd620, 11'd40);
    do_split(8'h40, k);
    push_exp(k + 3, 8'hC0, 8'hFF, 6, 3'd1, 1'b0, 11'd620, 11'd40, 1, 7, 3'd1, 1'b1, 11'd624, 11'd40);
    wait_drain();
    check("drop_still_one", dropCount, 1);

    // levelStart during GAP flushes the remaining pending splits
    set_parent(2, 3'd3, 11'd50, 11'd50);
    set_parent(3, 3'd2, 11'd60, 11'd60);
    set_parent(4, 3'd2, 11'd70, 11'd70);
    do_split(8'h1C, k);
    push_exp(k + 3, 8'h04, 8'hFF, 2, 3'd2, 1'b0, 11'd50, 11'd50, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    initSize = 3'd2; initX = 11'd7; initY = 11'd9;
    levelStart = 1'b1;
    push_exp(k + 6, 8'h01, 8'h01, 0, 3'd2, 1'b0, 11'd7, 11'd9, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    levelStart = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk); #1;
    check("flush_active", active, 8'h01);
    check("flush_drop", dropCount, 2);
    check("flush_clr", allCleared, 0);
`ifdef SPLIT_SCORE_EN
    check("flush_score", score, 0);
`endif

    // Asynchronous reset in the middle of an issue
    set_parent(0, 3'd2, 11'd5, 11'd5);
    do_split(8'h01, k);
    @(posedge clk); #1;
    resetN = 1'b0;
    #1;
    check("mid_rst_start", start, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_drop", dropCount, 0);
    check("mid_rst_x", startTopX, 0);
    check("mid_rst_clr", allCleared, 0);
    repeat (3) @(posedge clk); #1;
    resetN = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("post_rst_active", active, 0);
    check("post_rst_clr", allCleared, 1);
    check("post_rst_queue", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bubble_split_ctrl.md
Name: bubble_split_ctrl

Overview:
- Sits directly upstream of the bubble object instances. Drives their start/size/direction/startTopX/startTopY and consumes their split/topLeftX/topLeftY/size_out.
- Owns NUM_SLOTS bubble slots and tracks which slots are active.
- On a split it re-launches the parent slot as the left child and allocates a free slot for the right child. On level start it seeds slot 0.

Parameters:
- NUM_SLOTS, 8, number of bubble instances managed (2..16)
- BASE_W, 8, pixel width of a size-0 bubble; width(s) = BASE_W << s
- X_MAX, 639, rightmost legal pixel column

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- levelStart  in  1  one-cycle pulse: clear all slots, seed slot 0
- initSize  in  3  size for the seeded bubble
- initX  in  11  seed top-left X
- initY  in  11  seed top-left Y
- split  in  NUM_SLOTS  per-slot split pulse from bubble instances
- parentX  in  NUM_SLOTS*11  packed topLeftX per slot (slot i at [11i+10:11i])
- parentY  in  NUM_SLOTS*11  packed topLeftY per slot
- parentSize  in  NUM_SLOTS*3  packed size_out per slot
- start  out  NUM_SLOTS  one-cycle launch pulse per slot
- size  out  NUM_SLOTS*3  registered size per slot
- direction  out  NUM_SLOTS  0 = left, 1 = right
- startTopX  out  NUM_SLOTS*11  launch X per slot
- startTopY  out  NUM_SLOTS*11  launch Y per slot
- active  out  NUM_SLOTS  slot holds a live bubble
- allCleared  out  1  no active slots, no pending splits, FSM idle
- dropCount  out  8  right children dropped for lack of a free slot, saturating

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending cleared.
- Capture:
  - On any edge where split[i]=1 and active[i]=1: set pending[i] and latch parentX/Y/Size of slot i into capture registers.
  - split on an inactive slot is ignored.
  - Several slots may split in the same cycle. All of them are captured.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If levelStart=1, levelStart wins. It clears pending and active, then loads slot 0 with size=initSize, dir=0, X=initX, Y=initY. Next state ISSUE.
  - Otherwise, if pending≠0, the controller selects the lowest index p with pending set, clears pending[p] and computes children (below). Next state ISSUE.
- Child computation for parent size s:
  - s≤1: the bubble pops. active[p] is cleared and no start is issued. Next state is GAP, with no start pulses.
  - s≥2, left child: slot p, size s-1, dir 0, X = parent X, Y = parent Y.
  - s≥2, right child: lowest-index inactive slot f≠p, size s-1, dir 1, Y = parent Y.
  - Right child X = parent X + (BASE_W << (s-1)), clamped to X_MAX - (BASE_W << (s-1)) + 1. The sum is computed in 12 bits.
  - No free slot: the right child is dropped and dropCount increments (saturating at 255).
- ISSUE:
  - start is asserted for exactly one cycle on each launched slot.
  - active is set for those slots on the same edge.
  - size/direction/startTopX/Y are already stable in this cycle and hold until the next launch of that slot.
  - Next state GAP.
- GAP: one idle cycle so the bubble movers register their launch, then IDLE.
- Latency: split sampled at edge E0 → start high in the cycle after edge E2 (the clock edge two cycles after E0). This holds with no contention; each additional pending split adds 3 cycles.
- levelStart in ISSUE/GAP: latched and serviced on the next IDLE. It still overrides pending.
- A split arriving on slot p while pending[p] is already set: it is ignored; the first capture wins.
- allCleared: registered; 1 iff active=0, pending=0, state=IDLE, and no levelStart latched.
- resetN low mid-operation: immediate return to reset values. Partially issued starts are cancelled.

Optional Feature:
- Macro SPLIT_SCORE_EN.
- When defined, adds output score[15:0].
- score += (5 - s) on every serviced split of size s. The increment is applied in the IDLE→ISSUE/GAP transition.
- score saturates at 16'hFFFF and clears on levelStart.
- When undefined, no port and no logic.

Test Plan:
- Reset then levelStart with initSize=3, X=100, Y=50 → after edge E2 (two cycles after levelStart is sampled), start=8'b00000001 for one cycle; size0=3, dir0=0, active=8'b00000001, allCleared=0.
- Slot 0 active, size 3, X=100: split[0] pulse → start=8'b00000011; slot0 size 2 dir 0 X=100; slot1 size 2 dir 1 X=132.
- split on slots 1 and 3 in the same cycle, both size 2 → slot 1 serviced first; slot 3 starts 3 cycles later; children occupy the lowest free slots in order.
- Parent size 1 split on the only active slot → no start pulse; active=0; allCleared=1 two cycles later.
- All 8 slots active, size-2 split on slot 5 → start=8'b00100000 only; dropCount=1. Separately, parent X=620, s=2 → right child X=X_MAX-15=624.
- levelStart asserted while in GAP with pending splits → pending flushed; only slot 0 launched; with SPLIT_SCORE_EN defined, score=0.
